// File: rtl/sram_1rw1r_responder_pkg.sv
// Shared constants and helpers for the OpenRAM 1rw1r responder.
// Wrappers size the responder from the common macro defines below.
package sram_1rw1r_responder_pkg;

   localparam int ADDR_SIZE  = 8;
   localparam int DATA_SIZE  = 32;
   localparam int WMASK_SIZE = 4;

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_READ,
      OP_WRITE
   } port0_op_e;

   // The collision counter sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sram_model_array.sv
// NUM_WORDS x DATA_WIDTH storage: one lane-masked write port and two
// registered read ports that return the pre-write word on a same-edge write.
module sram_model_array #(
   parameter int DATA_WIDTH  = 32,
   parameter int WMASK_WIDTH = 4,
   parameter int NUM_WORDS   = 256,
   parameter int IDX_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [WMASK_WIDTH-1:0] wmask,
   input  logic [IDX_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic                   re0,
   input  logic                   rclr0,
   input  logic [IDX_WIDTH-1:0]   raddr0,
   output logic [DATA_WIDTH-1:0]  rdata0,
   input  logic                   re1,
   input  logic                   rclr1,
   input  logic [IDX_WIDTH-1:0]   raddr1,
   output logic [DATA_WIDTH-1:0]  rdata1
);

   localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask[i]) begin
               mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Non-blocking reads sample mem before this edge's write lands.
   always_ff @(posedge clk) begin
      if (rclr0) begin
         rdata0 <= '0;
      end else if (re0) begin
         rdata0 <= mem[raddr0];
      end
   end

   always_ff @(posedge clk) begin
      if (rclr1) begin
         rdata1 <= '0;
      end else if (re1) begin
         rdata1 <= mem[raddr1];
      end
   end

endmodule

// File: rtl/sram_1rw1r_responder.sv
// Cycle-accurate stand-in for an OpenRAM 1rw1r macro that also flags
// same-address write/read collisions and out-of-range accesses.
module sram_1rw1r_responder
   import sram_1rw1r_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_SIZE,
   parameter int ADDR_WIDTH  = ADDR_SIZE,
   parameter int WMASK_WIDTH = WMASK_SIZE,
   parameter int NUM_WORDS   = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   collision,
   output logic                   oob,
   output logic [7:0]             collision_count
);

   localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(NUM_WORDS);

   port0_op_e op0;
   logic      rd1;
   logic      oob0;
   logic      oob1;
   logic      wr_en;
   logic      collision_now;
   logic      oob_now;

   // Accesses sampled during reset are treated as idle on both ports.
   always_comb begin
      op0 = OP_IDLE;
      if (!reset && !csb0) begin
         op0 = web0 ? OP_READ : OP_WRITE;
      end
   end

   assign rd1  = !reset && !csb1;
   assign oob0 = ({1'b0, addr0} >= DEPTH);
   assign oob1 = ({1'b0, addr1} >= DEPTH);

   assign wr_en         = (op0 == OP_WRITE) && !oob0;
   assign collision_now = wr_en && rd1 && !oob1 && (addr0 == addr1);
   assign oob_now       = ((op0 != OP_IDLE) && oob0) || (rd1 && oob1);

   sram_model_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WMASK_WIDTH (WMASK_WIDTH),
      .NUM_WORDS   (NUM_WORDS),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_array (
      .clk    (clk),
      .we     (wr_en),
      .wmask  (wmask0),
      .waddr  (addr0[IDX_WIDTH-1:0]),
      .wdata  (din0),
      .re0    ((op0 == OP_READ) && !oob0),
      .rclr0  (reset || ((op0 == OP_READ) && oob0)),
      .raddr0 (addr0[IDX_WIDTH-1:0]),
      .rdata0 (dout0),
      .re1    (rd1 && !oob1),
      .rclr1  (reset || (rd1 && oob1)),
      .raddr1 (addr1[IDX_WIDTH-1:0]),
      .rdata1 (dout1)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         collision       <= 1'b0;
         oob             <= 1'b0;
         collision_count <= '0;
      end else begin
         collision <= collision_now;
         oob       <= oob_now;
         if (collision_now) begin
            collision_count <= sat_inc8(collision_count);
         end
      end
   end

endmodule

// File: tb/tb_sram_1rw1r_responder.sv
// Scoreboard bench for sram_1rw1r_responder with a 200-word array,
// so addresses 200..255 exercise the out-of-range path.
module tb_sram_1rw1r_responder;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int MW    = 4;
   localparam int DEPTH = 200;

   typedef struct packed {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          col;
      logic          oob;
      logic [7:0]    cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          csb0;
   logic          web0;
   logic [MW-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;
   logic          csb1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] dout1;
   logic          collision;
   logic          oob;
   logic [7:0]    collision_count;

   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] d0_m;
   logic [DW-1:0] d1_m;
   logic [7:0]    cnt_m;
   exp_t          exp_q [$];

   int errors = 0;
   int checks = 0;

   sram_1rw1r_responder #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .WMASK_WIDTH (MW),
      .NUM_WORDS   (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .csb0            (csb0),
      .web0            (web0),
      .wmask0          (wmask0),
      .addr0           (addr0),
      .din0            (din0),
      .dout0           (dout0),
      .csb1            (csb1),
      .addr1           (addr1),
      .dout1           (dout1),
      .collision       (collision),
      .oob             (oob),
      .collision_count (collision_count)
   );

   always #5 clk = ~clk;

   // Predict one edge from the reference memory, push it, then apply it to the DUT.
   task automatic drive(input logic rst, input logic c0, input logic w0,
                        input logic [MW-1:0] m0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] di, input logic c1, input logic [AW-1:0] a1);
      exp_t e;
      bit   in0;
      bit   in1;
      in0 = int'(a0) < DEPTH;
      in1 = int'(a1) < DEPTH;
      if (rst) begin
         d0_m  = '0;
         d1_m  = '0;
         cnt_m = '0;
         e.col = 1'b0;
         e.oob = 1'b0;
      end else begin
         e.oob = (!c0 && !in0) || (!c1 && !in1);
         e.col = !c0 && !w0 && !c1 && in0 && in1 && (a0 == a1);
         if (!c1) d1_m = in1 ? mem_m[int'(a1)] : '0;
         if (!c0 && w0) d0_m = in0 ? mem_m[int'(a0)] : '0;
         if (e.col && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
         if (!c0 && !w0 && in0) begin
            for (int i = 0; i < MW; i++) begin
               if (m0[i]) mem_m[int'(a0)][i*8 +: 8] = di[i*8 +: 8];
            end
         end
      end
      e.d0  = d0_m;
      e.d1  = d1_m;
      e.cnt = cnt_m;
      exp_q.push_back(e);
      reset  = rst;
      csb0   = c0;
      web0   = w0;
      wmask0 = m0;
      addr0  = a0;
      din0   = di;
      csb1   = c1;
      addr1  = a1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
         e = exp_q.pop_front();
      end
      checks += 5;
      if (dout0 !== e.d0) begin errors++; $display("[TB] FAIL reset_dout0: got %h expected %h", dout0, e.d0); end
      if (dout1 !== e.d1) begin errors++; $display("[TB] FAIL reset_dout1: got %h expected %h", dout1, e.d1); end
      if (collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision: got %b expected 0", collision); end
      if (oob !== 1'b0) begin errors++; $display("[TB] FAIL reset_oob: got %b expected 0", oob); end
      if (collision_count !== e.cnt) begin errors++; $display("[TB] FAIL reset_count: got %0d expected %0d", collision_count, e.cnt); end
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 1'b0, 1'b0, 4'hF, AW'(a), $urandom, 1'b1, '0);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      drive(1'b0, 1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, '0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h10, '0, 1'b0, 8'h10);
      e = exp_q.pop_front();
      checks += 3;
      if (dout0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_rd_dout0: got %h expected deadbeef", dout0); end
      if (dout1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_rd_dout1: got %h expected deadbeef", dout1); end
      if (collision !== e.col) begin errors++; $display("[TB] FAIL dual_read_no_collision: got %b expected %b", collision, e.col); end
   endtask

   task automatic test_partial_write();
      drive(1'b0, 1'b0, 1'b0, 4'b0101, 8'h10, 32'h11223344, 1'b1, '0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h10, '0, 1'b1, '0);
      void'(exp_q.pop_front());
      checks++;
      if (dout0 !== 32'hDE22BE44) begin errors++; $display("[TB] FAIL partial_write: got %h expected de22be44", dout0); end
   endtask

   task automatic test_collision();
      exp_t e;
      drive(1'b0, 1'b0, 1'b0, 4'hF, 8'h20, 32'h12345678, 1'b1, '0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 4'hF, 8'h20, 32'hAAAAAAAA, 1'b0, 8'h20);
      void'(exp_q.pop_front());
      checks += 3;
      if (dout1 !== 32'h12345678) begin errors++; $display("[TB] FAIL collision_old_data: got %h expected 12345678", dout1); end
      if (collision !== 1'b1) begin errors++; $display("[TB] FAIL collision_pulse: got %b expected 1", collision); end
      if (collision_count !== 8'd1) begin errors++; $display("[TB] FAIL collision_count_1: got %0d expected 1", collision_count); end
      drive(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b0, 8'h20);
      void'(exp_q.pop_front());
      checks += 2;
      if (collision !== 1'b0) begin errors++; $display("[TB] FAIL collision_one_cycle: got %b expected 0", collision); end
      if (dout1 !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL collision_write_done: got %h expected aaaaaaaa", dout1); end
      for (int i = 0; i < 300; i++) begin
         drive(1'b0, 1'b0, 1'b0, 4'hF, 8'h20, $urandom, 1'b0, 8'h20);
         e = exp_q.pop_front();
         checks += 2;
         if (collision_count !== e.cnt) begin errors++; $display("[TB] FAIL collision_count_step: got %0d expected %0d", collision_count, e.cnt); end
         if (dout1 !== e.d1) begin errors++; $display("[TB] FAIL collision_burst_dout1: got %h expected %h", dout1, e.d1); end
      end
      checks++;
      if (collision_count !== 8'd255) begin errors++; $display("[TB] FAIL collision_saturate: got %0d expected 255", collision_count); end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      drive(1'b0, 1'b0, 1'b0, 4'hF, 8'd210, 32'hFFFFFFFF, 1'b1, '0);
      void'(exp_q.pop_front());
      checks++;
      if (oob !== 1'b1) begin errors++; $display("[TB] FAIL oob_write: got %b expected 1", oob); end
      drive(1'b0, 1'b0, 1'b1, '0, 8'd210, '0, 1'b1, '0);
      void'(exp_q.pop_front());
      checks += 2;
      if (oob !== 1'b1) begin errors++; $display("[TB] FAIL oob_read: got %b expected 1", oob); end
      if (dout0 !== 32'h0) begin errors++; $display("[TB] FAIL oob_read_zero: got %h expected 0", dout0); end
      idle();
      void'(exp_q.pop_front());
      checks += 2;
      if (oob !== 1'b0) begin errors++; $display("[TB] FAIL oob_one_cycle: got %b expected 0", oob); end
      if (dout0 !== 32'h0) begin errors++; $display("[TB] FAIL oob_idle_hold: got %h expected 0", dout0); end
      drive(1'b0, 1'b0, 1'b1, '0, 8'd10, '0, 1'b1, '0);
      e = exp_q.pop_front();
      checks++;
      if (dout0 !== e.d0) begin errors++; $display("[TB] FAIL oob_no_alias: got %h expected %h", dout0, e.d0); end
      drive(1'b0, 1'b0, 1'b0, 4'hF, 8'd210, 32'h0BADF00D, 1'b0, 8'd210);
      e = exp_q.pop_front();
      checks += 3;
      if (collision !== 1'b0) begin errors++; $display("[TB] FAIL oob_no_collision: got %b expected 0", collision); end
      if (oob !== 1'b1) begin errors++; $display("[TB] FAIL oob_both_ports: got %b expected 1", oob); end
      if (dout1 !== e.d1) begin errors++; $display("[TB] FAIL oob_dout1_zero: got %h expected %h", dout1, e.d1); end
   endtask

   task automatic test_reset_midstream();
      logic [DW-1:0] old;
      old = mem_m[5];
      drive(1'b1, 1'b0, 1'b0, 4'hF, 8'h05, ~old, 1'b0, 8'h05);
      void'(exp_q.pop_front());
      checks += 5;
      if (dout0 !== 32'h0) begin errors++; $display("[TB] FAIL midreset_dout0: got %h expected 0", dout0); end
      if (dout1 !== 32'h0) begin errors++; $display("[TB] FAIL midreset_dout1: got %h expected 0", dout1); end
      if (collision !== 1'b0) begin errors++; $display("[TB] FAIL midreset_collision: got %b expected 0", collision); end
      if (oob !== 1'b0) begin errors++; $display("[TB] FAIL midreset_oob: got %b expected 0", oob); end
      if (collision_count !== 8'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", collision_count); end
      drive(1'b0, 1'b0, 1'b1, '0, 8'h05, '0, 1'b1, '0);
      void'(exp_q.pop_front());
      checks++;
      if (dout0 !== old) begin errors++; $display("[TB] FAIL midreset_no_write: got %h expected %h", dout0, old); end
   endtask

   task automatic test_random_traffic();
      exp_t          e;
      logic          c0;
      logic          w0;
      logic          c1;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      for (int n = 0; n < 10000; n++) begin
         c0 = ($urandom_range(0, 3) == 0);
         c1 = ($urandom_range(0, 3) == 0);
         w0 = $urandom_range(0, 1) == 1;
         a0 = AW'($urandom_range(0, 219));
         a1 = ($urandom_range(0, 4) == 0) ? a0 : AW'($urandom_range(0, 219));
         drive(1'b0, c0, w0, MW'($urandom), a0, $urandom, c1, a1);
         e = exp_q.pop_front();
         checks += 5;
         if (dout0 !== e.d0) begin errors++; $display("[TB] FAIL rand_dout0 cycle %0d: got %h expected %h", n, dout0, e.d0); end
         if (dout1 !== e.d1) begin errors++; $display("[TB] FAIL rand_dout1 cycle %0d: got %h expected %h", n, dout1, e.d1); end
         if (collision !== e.col) begin errors++; $display("[TB] FAIL rand_collision cycle %0d: got %b expected %b", n, collision, e.col); end
         if (oob !== e.oob) begin errors++; $display("[TB] FAIL rand_oob cycle %0d: got %b expected %b", n, oob, e.oob); end
         if (collision_count !== e.cnt) begin errors++; $display("[TB] FAIL rand_count cycle %0d: got %0d expected %0d", n, collision_count, e.cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_collision();
      test_out_of_range();
      test_reset_midstream();
      test_random_traffic();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
